// File: rtl/adder_rr_pkg.sv
// Shared constants, types and the round-robin pick helper for adder_rr_sched.
package adder_rr_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_IDW   = 2;
    localparam int unsigned MAX_NREQ  = 8;
    localparam int unsigned MAX_IDW   = 3;

    // Result register contents for the default configuration.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
        logic [DEF_IDW-1:0]   id;
    } res_t;

    // Outcome of a round-robin search.
    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, wrapping modulo nreq.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                      input logic [MAX_IDW-1:0]  ptr,
                                      input int unsigned         nreq);
        pick_t       p;
        int unsigned j;
        p = '0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= nreq) begin
                j = j - nreq;
            end
            if ((k < nreq) && !p.found && valid[MAX_IDW'(j)]) begin
                p.found = 1'b1;
                p.idx   = MAX_IDW'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/adder_rr_sched_ripple_add_w.sv
// Combinational WIDTH-bit ripple-carry adder, carry-in tied low.
module ripple_add_w #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    // One full-adder cell per bit, chained through carry.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
        assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one ripple adder among NREQ requesters.
// Optional: define ADDER_RR_SAT_EN to saturate res_sum to all-ones on carry-out.
module adder_rr_sched
    import adder_rr_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned IDW   = DEF_IDW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_cout,
    output logic [IDW-1:0]        res_id,
    output logic [7:0]            busy_cnt
);

    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q,   res_sum_d;
    logic             res_cout_q,  res_cout_d;
    logic [IDW-1:0]   res_id_q,    res_id_d;
    logic [7:0]       busy_cnt_q,  busy_cnt_d;

    logic             free_c;
    logic             grant_c;
    pick_t            pick_c;
    logic [WIDTH-1:0] a_sel_c, b_sel_c;
    logic [WIDTH-1:0] add_sum_c;
    logic             add_cout_c;

    // Grant search and operand selection; grant depends only on valid, ptr and slot state.
    always_comb begin
        free_c    = !res_valid_q || res_ready;
        pick_c    = rr_pick(MAX_NREQ'(req_valid), MAX_IDW'(ptr_q), NREQ);
        grant_c   = free_c && pick_c.found && !reset;
        req_ready = '0;
        a_sel_c   = '0;
        b_sel_c   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_c && (pick_c.idx == MAX_IDW'(i));
            if (pick_c.idx == MAX_IDW'(i)) begin
                a_sel_c = req_a[i*WIDTH +: WIDTH];
                b_sel_c = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    ripple_add_w #(.WIDTH(WIDTH)) u_add (
        .a_i    (a_sel_c),
        .b_i    (b_sel_c),
        .sum_o  (add_sum_c),
        .cout_o (add_cout_c)
    );

    // Next state for the pointer, output register and transfer counter.
    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_id_d    = res_id_q;
        busy_cnt_d  = busy_cnt_q;
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            busy_cnt_d  = busy_cnt_q + 8'd1;
        end
        if (grant_c) begin
            res_valid_d = 1'b1;
`ifdef ADDER_RR_SAT_EN
            res_sum_d   = add_cout_c ? '1 : add_sum_c;
`else
            res_sum_d   = add_sum_c;
`endif
            res_cout_d  = add_cout_c;
            res_id_d    = IDW'(pick_c.idx);
            if (32'(pick_c.idx) + 32'd1 >= NREQ) begin
                ptr_d = '0;
            end else begin
                ptr_d = IDW'(pick_c.idx + MAX_IDW'(1));
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
            busy_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_id_q    <= res_id_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed self-checking bench for adder_rr_sched (default 8-bit, 4 requesters).
module tb_adder_rr_sched;
    import adder_rr_pkg::*;

    localparam int unsigned W = DEF_WIDTH;
    localparam int unsigned N = DEF_NREQ;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_sum;
    logic             res_cout;
    logic [DEF_IDW-1:0] res_id;
    logic [7:0]       busy_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rr_a   [4] = '{8'h01, 8'h11, 8'h21, 8'h31};
    logic [7:0] rr_b   [4] = '{8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] rr_sum [4] = '{8'h03, 8'h14, 8'h25, 8'h36};
    logic [7:0] ovf_sum;
    res_t       held;

    adder_rr_sched dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input res_t e, input logic vld, input logic [7:0] cnt);
        chk({tag, "_valid"}, 32'(res_valid), 32'(vld));
        chk({tag, "_sum"},   32'(res_sum),   32'(e.sum));
        chk({tag, "_cout"},  32'(res_cout),  32'(e.cout));
        chk({tag, "_id"},    32'(res_id),    32'(e.id));
        chk({tag, "_cnt"},   32'(busy_cnt),  32'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef ADDER_RR_SAT_EN
        ovf_sum = 8'hFF;
`else
        ovf_sum = 8'h00;
`endif
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        next_cycle();

        // Reset held with all requesters valid
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_valid", 32'(res_valid), 32'h0);
            chk("rst_cnt",   32'(busy_cnt),  32'h0);
            next_cycle();
        end
        reset = 1'b0;

        // Single add from requester 0
        req_valid = 4'b0001;
        set_ops(0, 8'h0B, 8'h04);
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        chk_res("single", '{sum: 8'h0F, cout: 1'b0, id: 2'd0}, 1'b1, 8'd0);
        next_cycle();

        // Overflow from requester 1 (pointer now at 1)
        req_valid = 4'b0010;
        set_ops(1, 8'hFF, 8'h01);
        @(negedge clk);
        chk("ovf_ready", 32'(req_ready), 32'h2);
        chk("drain_cnt", 32'(busy_cnt),  32'd1);
        chk("drain_vld", 32'(res_valid), 32'd0);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        chk_res("ovf", '{sum: ovf_sum, cout: 1'b1, id: 2'd1}, 1'b1, 8'd1);
        next_cycle();

        // Requester 3 moves the pointer back to 0
        req_valid = 4'b1000;
        set_ops(3, 8'h10, 8'h20);
        @(negedge clk);
        chk("r3_ready", 32'(req_ready), 32'h8);
        next_cycle();
        for (int i = 0; i < 4; i++) set_ops(i, rr_a[i], rr_b[i]);
        req_valid = 4'b1111;
        @(negedge clk);
        chk_res("r3", '{sum: 8'h30, cout: 1'b0, id: 2'd3}, 1'b1, 8'd2);
        chk("rr_ready0", 32'(req_ready), 32'h1);

        // Round-robin rotation with continuous draining
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            @(negedge clk);
            held = '{sum: rr_sum[k % 4], cout: 1'b0, id: 2'(k % 4)};
            chk_res($sformatf("rr%0d", k), held, 1'b1, 8'(3 + k));
            chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << ((k + 1) % 4)));
        end

        // Backpressure: result for requester 3 held for three cycles
        res_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(req_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk_res($sformatf("bp%0d", c), '{sum: 8'h36, cout: 1'b0, id: 2'd3}, 1'b1, 8'd10);
            chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h1);
        next_cycle();
        @(negedge clk);
        chk_res("nobubble", '{sum: 8'h03, cout: 1'b0, id: 2'd0}, 1'b1, 8'd11);

        // Mid-operation reset while a result is stalled
        res_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("stall_valid", 32'(res_valid), 32'd1);
        reset     = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'h0);
        next_cycle();
        @(negedge clk);
        chk_res("rst_mid", '{sum: 8'h00, cout: 1'b0, id: 2'd0}, 1'b0, 8'd0);
        reset     = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        next_cycle();
        @(negedge clk);
        chk_res("post_rst", '{sum: 8'h03, cout: 1'b0, id: 2'd0}, 1'b1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Round-robin scheduler that shares one WIDTH-bit ripple-carry adder among NREQ independent requesters.
- Each requester presents an operand pair through a valid/ready handshake. The scheduler grants one requester per cycle and launches its addition.
- Each result is held in a single output register, tagged with the requester index, until the consumer accepts it.
- Sits between the requesting datapath blocks and the shared adder resource.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-index width; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has an operand pair pending.
- req_ready  out  NREQ  bit i: requester i is granted this cycle (one-hot or zero).
- req_a  in  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same slicing as req_a.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  consumer accepts the result this cycle.
- res_sum  out  WIDTH  registered sum.
- res_cout  out  1  registered carry-out of the MSB.
- res_id  out  IDW  index of the requester that produced the result.
- busy_cnt  out  8  count of completed transfers (res_valid & res_ready); wraps 255 -> 0.

Behaviour:
- Reset:
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, busy_cnt=0.
  - Round-robin pointer ptr=0.
  - req_ready is combinationally 0 while reset is high.
- Slot free condition: free = !res_valid | res_ready. A result being drained frees the slot in the same cycle, so full throughput is one add per cycle.
- Grant (combinational):
  - If free, search req_valid starting at ptr, ascending with wrap modulo NREQ.
  - The first asserted bit j gets req_ready[j]=1; all other bits are 0.
  - If not free, or no req_valid is set, req_ready=0.
  - req_ready must not depend on req_a or req_b.
- Transfer: a transfer from requester j occurs when req_valid[j] & req_ready[j].
- On the edge after a transfer from j:
  - res_sum <= a_j + b_j, carry-in 0, truncated to WIDTH bits.
  - res_cout <= carry out of bit WIDTH-1.
  - res_id <= j; res_valid <= 1.
  - ptr <= (j+1) mod NREQ.
- Latency: a transfer in cycle t presents its result in cycle t+1.
- Output path:
  - If res_valid & res_ready and there is no new transfer, res_valid <= 0. Data outputs hold their last value.
  - Simultaneous drain and new transfer: res_valid stays 1 and the register loads the new result. No bubble, no loss.
  - While res_valid & !res_ready: res_sum, res_cout and res_id are stable, and req_ready=0.
- Pointer: ptr is unchanged in any cycle without a transfer.
- Fairness: under continuous requests from all requesters and res_ready=1, grants rotate 0,1,...,NREQ-1.
- busy_cnt increments on each res_valid & res_ready.
- Reset mid-operation: a pending result is discarded without handshake, and every register returns to its reset value on the next edge.
- Requester contract (not checked): a requester holds req_a and req_b stable while req_valid=1 and it is not granted.

Optional Feature:
- Macro name: ADDER_RR_SAT_EN.
- Defined:
  - res_sum saturates to all-ones (2^WIDTH-1) whenever the carry-out is 1.
  - res_cout still reports the raw carry, so overflow remains visible.
- Undefined:
  - res_sum is the wrapped WIDTH-bit sum.
  - No saturation logic is synthesized.

Decomposition:
- Package adder_rr_pkg holds:
  - Default constants DEF_WIDTH=8 and DEF_NREQ=4.
  - Function rr_pick(valid, ptr), returning a found flag and an index.
  - A typedef for a result struct {sum, cout, id}.
- One sub-module, ripple_add_w:
  - Parameterized WIDTH-bit ripple-carry adder built from a generate loop of one-bit full-adder cells, carry-in tied 0.
  - Purely combinational, instantiated once as the shared resource.
- The scheduler holds all sequential state: pointer, output register and counter.

Test Plan:
- Reset sequence: hold reset 2 cycles with req_valid=4'b1111 -> req_ready=0, res_valid=0, busy_cnt=0 throughout.
- Single add: req0 a=0x0B, b=0x04, res_ready=1 -> next cycle res_valid=1, res_sum=0x0F, res_cout=0, res_id=0.
- Overflow: a=0xFF, b=0x01 -> res_sum=0x00, res_cout=1; with ADDER_RR_SAT_EN defined -> res_sum=0xFF, res_cout=1.
- Round-robin: all four valid, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3 and busy_cnt=8.
- Backpressure:
  - res_ready=0 for 3 cycles with a result held -> req_ready=0 and outputs stable.
  - Raise res_ready -> drain and new grant occur in the same cycle, with no bubble.
- Mid-operation reset: assert reset while res_valid=1 and res_ready=0 -> res_valid=0 and ptr=0 next cycle; the first grant afterwards goes to the lowest valid index.
